// File: rtl/cpc_ram_sequencer.sv
// Arbitrates CPU byte accesses and 16-bit video word fetches onto one byte-wide
// request/acknowledge memory port. Video has priority; the CPU stalls on cpu_wait.
module cpc_ram_sequencer #(
    parameter logic [6:0] VID_BASE = 7'b0000010
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_A,
    input  logic [7:0]  cpu_D,
    output logic [7:0]  cpu_Q,
    output logic        cpu_wait,
    input  logic        vid_req,
    input  logic [15:0] vid_A,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    output logic        vid_ovf,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [22:0] mem_A,
    output logic [7:0]  mem_DO,
    input  logic [7:0]  mem_DI,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {StIdle, StCpu, StVlo, StVhi} state_e;

    state_e      state_q, state_d;
    logic        cpu_rd_q, cpu_wr_q;
    logic        cpu_pend_q, cpu_is_wr_q;
    logic [22:0] cpu_a_q;
    logic [7:0]  cpu_d_q;
    logic        vid_pend_q;
    logic [14:0] vid_a_q;
    logic [7:0]  vid_lo_q;

    logic        cpu_edge, cpu_done, vid_lo_done, vid_done;
    logic        mem_rd_d, mem_wr_d;
    logic [22:0] mem_a_d;
    logic [7:0]  mem_do_d, cpu_q_d;
    logic [15:0] vid_data_d;
    logic        vid_valid_d;
    logic        unused_vid_a0;

    assign unused_vid_a0 = vid_A[0];
    assign cpu_edge      = (cpu_rd & ~cpu_rd_q) | (cpu_wr & ~cpu_wr_q);
    assign cpu_done      = (state_q == StCpu) & mem_ack;
    assign vid_lo_done   = (state_q == StVlo) & mem_ack;
    assign vid_done      = (state_q == StVhi) & mem_ack;
    // The pending CPU slot and the stall are the same condition.
    assign cpu_wait      = cpu_pend_q;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            cpu_rd_q    <= 1'b0;
            cpu_wr_q    <= 1'b0;
            cpu_pend_q  <= 1'b0;
            cpu_is_wr_q <= 1'b0;
            cpu_a_q     <= '0;
            cpu_d_q     <= '0;
            vid_pend_q  <= 1'b0;
            vid_a_q     <= '0;
            vid_lo_q    <= '0;
            vid_ovf     <= 1'b0;
        end else begin
            cpu_rd_q <= cpu_rd;
            cpu_wr_q <= cpu_wr;
            if (cpu_done) begin
                cpu_pend_q <= 1'b0;
            end else if (cpu_edge && !cpu_pend_q) begin
                cpu_pend_q  <= 1'b1;
                cpu_is_wr_q <= cpu_wr & ~cpu_wr_q;  // write wins on a joint edge
                cpu_a_q     <= cpu_A;
                cpu_d_q     <= cpu_D;
            end
            // The video slot stays set until the high byte is acknowledged.
            if (vid_done) begin
                vid_pend_q <= 1'b0;
            end else if (vid_req && !vid_pend_q) begin
                vid_pend_q <= 1'b1;
                vid_a_q    <= vid_A[15:1];
            end
            if (vid_req && vid_pend_q) begin
                vid_ovf <= 1'b1;
            end
            if (vid_lo_done) begin
                vid_lo_q <= mem_DI;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (vid_pend_q) begin
                    state_d = StVlo;
                end else if (cpu_pend_q) begin
                    state_d = StCpu;
                end
            end
            StCpu:   if (mem_ack) state_d = StIdle;
            StVlo:   if (mem_ack) state_d = StVhi;
            StVhi:   if (mem_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so requests are registered from FSM entry.
    always_comb begin
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_a_d     = mem_A;
        mem_do_d    = mem_DO;
        cpu_q_d     = cpu_Q;
        vid_data_d  = vid_data;
        vid_valid_d = vid_done;
        unique case (state_d)
            StCpu: begin
                mem_rd_d = ~cpu_is_wr_q;
                mem_wr_d = cpu_is_wr_q;
                mem_a_d  = cpu_a_q;
                mem_do_d = cpu_d_q;
            end
            StVlo: begin
                mem_rd_d = 1'b1;
                mem_a_d  = {VID_BASE, vid_a_q, 1'b0};
            end
            StVhi: begin
                mem_rd_d = 1'b1;
                mem_a_d  = {VID_BASE, vid_a_q, 1'b1};
            end
            default: ;
        endcase
        if (cpu_done && !cpu_is_wr_q) begin
            cpu_q_d = mem_DI;
        end
        if (vid_done) begin
            vid_data_d = {mem_DI, vid_lo_q};
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_A     <= '0;
            mem_DO    <= '0;
            cpu_Q     <= '0;
            vid_data  <= '0;
            vid_valid <= 1'b0;
        end else begin
            mem_rd    <= mem_rd_d;
            mem_wr    <= mem_wr_d;
            mem_A     <= mem_a_d;
            mem_DO    <= mem_do_d;
            cpu_Q     <= cpu_q_d;
            vid_data  <= vid_data_d;
            vid_valid <= vid_valid_d;
        end
    end

endmodule

// File: tb/tb_cpc_ram_sequencer.sv
// Directed bench for cpc_ram_sequencer: CPU read/write, video fetch, priority,
// overflow and mid-transaction reset, with hand-computed expectations.
module tb_cpc_ram_sequencer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [22:0] cpu_A;
    logic [7:0]  cpu_D, cpu_Q;
    logic        cpu_wait;
    logic        vid_req;
    logic [15:0] vid_A, vid_data;
    logic        vid_valid, vid_ovf;
    logic        mem_rd, mem_wr;
    logic [22:0] mem_A;
    logic [7:0]  mem_DO, mem_DI;
    logic        mem_ack;

    int errors = 0;
    int checks = 0;
    int extra;

    cpc_ram_sequencer dut (
        .CLK      (CLK),
        .reset    (reset),
        .cpu_rd   (cpu_rd),
        .cpu_wr   (cpu_wr),
        .cpu_A    (cpu_A),
        .cpu_D    (cpu_D),
        .cpu_Q    (cpu_Q),
        .cpu_wait (cpu_wait),
        .vid_req  (vid_req),
        .vid_A    (vid_A),
        .vid_data (vid_data),
        .vid_valid(vid_valid),
        .vid_ovf  (vid_ovf),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_A    (mem_A),
        .mem_DO   (mem_DO),
        .mem_DI   (mem_DI),
        .mem_ack  (mem_ack)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hold mem_ack high for one cycle after n idle cycles.
    task automatic ack(input int n, input logic [7:0] d);
        repeat (n) tick();
        mem_DI  = d;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_DI  = 8'h00;
    endtask

    initial begin
        reset = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_A = '0; cpu_D = '0;
        vid_req = 1'b0; vid_A = '0; mem_DI = '0; mem_ack = 1'b0;
        tick(); tick();
        check("rst_cpu_Q", cpu_Q, 0);
        check("rst_cpu_wait", cpu_wait, 0);
        check("rst_vid_data", vid_data, 0);
        check("rst_vid_valid", vid_valid, 0);
        check("rst_vid_ovf", vid_ovf, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_A", mem_A, 0);
        check("rst_mem_DO", mem_DO, 0);
        reset = 1'b0;
        tick();

        // CPU read, ack two cycles after mem_rd rises
        cpu_A = 23'h020123; cpu_rd = 1'b1;
        tick();
        check("rd_wait_set", cpu_wait, 1);
        check("rd_no_req_yet", mem_rd, 0);
        tick();
        check("rd_mem_rd", mem_rd, 1);
        check("rd_mem_wr", mem_wr, 0);
        check("rd_mem_A", mem_A, 23'h020123);
        tick();
        check("rd_wait_hold", cpu_wait, 1);
        ack(0, 8'h5A);
        check("rd_wait_clr", cpu_wait, 0);
        check("rd_cpu_Q", cpu_Q, 8'h5A);
        check("rd_mem_rd_off", mem_rd, 0);
        cpu_rd = 1'b0;
        tick();

        // CPU write
        cpu_A = 23'h7FFFFF; cpu_D = 8'hC3; cpu_wr = 1'b1;
        tick();
        check("wr_wait_set", cpu_wait, 1);
        tick();
        check("wr_mem_wr", mem_wr, 1);
        check("wr_mem_rd", mem_rd, 0);
        check("wr_mem_A", mem_A, 23'h7FFFFF);
        check("wr_mem_DO", mem_DO, 8'hC3);
        ack(0, 8'hEE);
        check("wr_wait_clr", cpu_wait, 0);
        check("wr_cpu_Q_kept", cpu_Q, 8'h5A);
        check("wr_mem_wr_off", mem_wr, 0);
        cpu_wr = 1'b0;
        tick();

        // Video fetch, odd address rounds down
        vid_A = 16'hC001; vid_req = 1'b1;
        tick();
        vid_req = 1'b0;
        tick();
        check("v_lo_rd", mem_rd, 1);
        check("v_lo_A", mem_A, 23'h02C000);
        ack(1, 8'h11);
        check("v_hi_rd", mem_rd, 1);
        check("v_hi_A", mem_A, 23'h02C001);
        ack(0, 8'h22);
        check("v_valid", vid_valid, 1);
        check("v_data", vid_data, 16'h2211);
        check("v_rd_off", mem_rd, 0);
        tick();
        check("v_valid_pulse", vid_valid, 0);
        check("v_ovf_clear", vid_ovf, 0);

        // Simultaneous video request and CPU edge: video goes first
        vid_A = 16'h1234; vid_req = 1'b1; cpu_A = 23'h012345; cpu_rd = 1'b1;
        tick();
        vid_req = 1'b0;
        tick();
        check("pri_lo_A", mem_A, 23'h021234);
        check("pri_lo_rd", mem_rd, 1);
        ack(0, 8'hAA);
        check("pri_hi_A", mem_A, 23'h021235);
        ack(0, 8'hBB);
        check("pri_vdata", vid_data, 16'hBBAA);
        check("pri_gap", mem_rd, 0);
        check("pri_cpu_waiting", cpu_wait, 1);
        tick();
        check("pri_cpu_rd", mem_rd, 1);
        check("pri_cpu_A", mem_A, 23'h012345);
        ack(0, 8'h77);
        check("pri_cpu_Q", cpu_Q, 8'h77);
        check("pri_wait_clr", cpu_wait, 0);
        cpu_rd = 1'b0;
        tick();

        // Second request during the VHI wait overflows
        vid_A = 16'h0010; vid_req = 1'b1;
        tick();
        vid_req = 1'b0;
        tick();
        ack(0, 8'h01);
        check("ovf_hi_A", mem_A, 23'h020011);
        vid_A = 16'h0020; vid_req = 1'b1;
        tick();
        vid_req = 1'b0;
        check("ovf_set", vid_ovf, 1);
        ack(0, 8'h02);
        check("ovf_valid", vid_valid, 1);
        check("ovf_data", vid_data, 16'h0201);
        extra = 0;
        repeat (4) begin
            tick();
            if (vid_valid || mem_rd) extra++;
        end
        check("ovf_single_fetch", extra, 0);
        check("ovf_sticky", vid_ovf, 1);

        // Reset in the middle of a CPU read
        cpu_A = 23'h000777; cpu_rd = 1'b1;
        tick();
        tick();
        check("mrst_mem_rd_before", mem_rd, 1);
        reset = 1'b1;
        #1;
        check("mrst_mem_rd", mem_rd, 0);
        check("mrst_mem_A", mem_A, 0);
        check("mrst_cpu_wait", cpu_wait, 0);
        check("mrst_vid_ovf", vid_ovf, 0);
        check("mrst_vid_data", vid_data, 0);
        cpu_rd = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        cpu_A = 23'h045678; cpu_rd = 1'b1;
        tick();
        tick();
        check("post_mem_rd", mem_rd, 1);
        check("post_mem_A", mem_A, 23'h045678);
        ack(1, 8'h3C);
        check("post_cpu_Q", cpu_Q, 8'h3C);
        check("post_wait_clr", cpu_wait, 0);
        cpu_rd = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
